// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: arbitrates instruction fetches and load/stores
// onto a single-port byte RAM, assembling little-endian words one byte per cycle.
module mem_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    input  logic        if_cancel,
    output logic        if_ack,
    output logic [31:0] if_data,
    input  logic        mm_req,
    input  logic        mm_we,
    input  logic [31:0] mm_addr,
    input  logic [1:0]  mm_len,
    input  logic [31:0] mm_wdata,
    output logic        mm_ack,
    output logic [31:0] mm_rdata,
    output logic [31:0] ram_addr,
    output logic        ram_wr,
    output logic [7:0]  ram_dout,
    input  logic [7:0]  ram_din,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, RD, WR} state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] base;
    logic [2:0]  len_n;
    logic        own_mm;
    logic        last_mm;
    logic [31:0] wbuf;
    logic [31:0] rbuf;
    logic [2:0]  cnt;

    logic        if_ok;
    logic        mm_ok;
    logic        grant_mm;
    logic        grant_if;
    logic        cancel_rd;
    logic        rd_done;
    logic        wr_done;
    logic [2:0]  cnt_inc;
    logic [31:0] addr_nxt;
    logic [1:0]  rd_idx;
    logic [1:0]  wr_idx;
    logic [31:0] rbuf_nxt;

    function automatic logic [2:0] len_bytes(input logic [1:0] len);
        case (len)
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    // A requester is not eligible in the cycle its own ack is still visible,
    // so a held req cannot restart the transaction that just finished.
    always_comb begin
        if_ok    = if_req && !if_cancel && !if_ack;
        mm_ok    = mm_req && !mm_ack;
        grant_mm = mm_ok && !(if_ok && last_mm);
        grant_if = if_ok && !grant_mm;
    end

    always_comb begin
        cnt_inc   = cnt + 3'd1;
        addr_nxt  = base + {29'd0, cnt_inc};
        rd_idx    = 2'(cnt - 3'd1);
        wr_idx    = cnt_inc[1:0];
        cancel_rd = (state == RD) && !own_mm && if_cancel;
        rd_done   = (state == RD) && (cnt == len_n);
        wr_done   = (state == WR) && (cnt_inc == len_n);
        rbuf_nxt  = rbuf;
        if (cnt != 3'd0)
            rbuf_nxt[{rd_idx, 3'b000} +: 8] = ram_din;
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (grant_mm)
                    state_nxt = mm_we ? WR : RD;
                else if (grant_if)
                    state_nxt = RD;
            end
            RD: begin
                if (cancel_rd || rd_done)
                    state_nxt = IDLE;
            end
            WR: begin
                if (wr_done)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        busy = (state != IDLE);
    end

    // RD: address for byte k is issued in cycle k+1; its data arrives one
    // cycle later, so capture lags the issue counter by one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            base     <= '0;
            len_n    <= '0;
            own_mm   <= 1'b0;
            last_mm  <= 1'b0;
            wbuf     <= '0;
            rbuf     <= '0;
            cnt      <= '0;
            ram_addr <= '0;
            ram_wr   <= 1'b0;
            ram_dout <= '0;
            if_ack   <= 1'b0;
            if_data  <= '0;
            mm_ack   <= 1'b0;
            mm_rdata <= '0;
        end else begin
            if_ack <= 1'b0;
            mm_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_mm || grant_if) begin
                        own_mm   <= grant_mm;
                        last_mm  <= grant_mm;
                        base     <= grant_mm ? mm_addr : if_addr;
                        ram_addr <= grant_mm ? mm_addr : if_addr;
                        len_n    <= grant_mm ? len_bytes(mm_len) : 3'd4;
                        wbuf     <= mm_wdata;
                        rbuf     <= '0;
                        cnt      <= '0;
                        if (grant_mm && mm_we) begin
                            ram_wr   <= 1'b1;
                            ram_dout <= mm_wdata[7:0];
                        end
                    end
                end
                RD: begin
                    if (cancel_rd) begin
                        cnt <= '0;
                    end else begin
                        rbuf <= rbuf_nxt;
                        if (rd_done) begin
                            cnt <= '0;
                            if (own_mm) begin
                                mm_rdata <= rbuf_nxt;
                                mm_ack   <= 1'b1;
                            end else begin
                                if_data <= rbuf_nxt;
                                if_ack  <= 1'b1;
                            end
                        end else begin
                            cnt <= cnt_inc;
                            if (cnt_inc < len_n)
                                ram_addr <= addr_nxt;
                        end
                    end
                end
                WR: begin
                    if (wr_done) begin
                        ram_wr <= 1'b0;
                        mm_ack <= 1'b1;
                        cnt    <= '0;
                    end else begin
                        cnt      <= cnt_inc;
                        ram_addr <= addr_nxt;
                        ram_dout <= wbuf[{wr_idx, 3'b000} +: 8];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
